tx_resp_scheduler: RTL and testbench

Response scheduler between the system controller's result sources and the UART transmit path, in the REF_CLK domain. It accepts single-cycle result pulses from two requesters (ALU result, register-file read data) and queues them in a small FIFO. It then issues one byte at a time to the TX data synchronizer, pacing sends with the synchronized UART TX busy flag so that no byte is lost while the slower TX domain is transmitting.

---
 rtl/tx_sched_pkg.sv | 19 +
 rtl/tx_sched_fifo.sv | 60 ++++++
 rtl/tx_resp_scheduler.sv | 170 +++++++++++++++++
 tb/tb_tx_resp_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_sched_pkg
// Brief    : Shared FSM state encoding and requester indices for tx_resp_scheduler.
// Revision : 1.0
// ============================================================================
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_RF  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tx_sched_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tx_sched_fifo
// Brief    : DEPTH x DATA_WIDTH FIFO, two ordered write ports, one read port.
// Revision : 1.0
// ============================================================================
module tx_sched_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr0_en,
  input  logic [DATA_WIDTH-1:0]    wr0_data,
  input  logic                     wr1_en,
  input  logic [DATA_WIDTH-1:0]    wr1_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW-1:0]         w_used;
  logic [AW-1:0]         w_waddr0;
  logic [AW-1:0]         w_waddr1;

  // Port 1 is only used together with port 0, so it lands in the following slot.
  assign w_waddr0 = r_wptr[AW-1:0];
  assign w_waddr1 = w_waddr0 + AW'(1);

  always_ff @(posedge clk) begin
    if (wr0_en) r_mem[w_waddr0] <= wr0_data;
    if (wr1_en) r_mem[w_waddr1] <= wr1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= r_wptr + PW'(wr0_en) + PW'(wr1_en);
      r_rptr <= r_rptr + PW'(rd_en);
    end
  end

  assign rd_data  = r_mem[r_rptr[AW-1:0]];
  assign empty    = (r_wptr == r_rptr);
  assign full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_used   = r_wptr - r_rptr;
  assign free_cnt = PW'(DEPTH) - w_used;

endmodule
`default_nettype wire

// File: rtl/tx_resp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_resp_scheduler
// Brief    : Queues ALU / register-file results and paces them byte by byte
//            to the UART TX synchronizer using the TX busy handshake.
//            TX_SCHED_RR_EN selects round-robin instead of fixed ALU priority.
// Revision : 1.0
// ============================================================================
module tx_resp_scheduler
  import tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 4,
  parameter int BUSY_WAIT_MAX = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_vld,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  rf_vld,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_d_vld,
  output logic                  fifo_full,
  output logic                  drop,
  output logic                  timeout,
  output logic                  idle
);

  localparam int CW = $clog2(BUSY_WAIT_MAX + 1);
  localparam int FW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_WAIT_MAX = CW'(BUSY_WAIT_MAX);

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [DATA_WIDTH-1:0] r_tx_p_data, w_tx_p_data_nxt;
  logic                  r_tx_d_vld, w_tx_d_vld_nxt;
  logic                  r_timeout, w_timeout_nxt;
  logic                  r_drop, w_drop_nxt;
  logic                  w_pop;

  logic                  w_wr0_en, w_wr1_en;
  logic [DATA_WIDTH-1:0] w_wr0_data, w_wr1_data;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_full, w_empty;
  logic [FW-1:0]         w_free;
  logic                  w_first_idx;
  logic                  w_both;

  assign w_both = alu_vld && rf_vld;

`ifdef TX_SCHED_RR_EN
  logic r_rr_first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_rr_first <= REQ_ALU;
    else if (w_both) r_rr_first <= ~r_rr_first;
  end

  assign w_first_idx = r_rr_first;
`else
  assign w_first_idx = REQ_ALU;
`endif

  // Free count comes from registered pointers, so a same-cycle pop never helps.
  always_comb begin
    w_wr0_en   = 1'b0;
    w_wr1_en   = 1'b0;
    w_wr0_data = alu_out;
    w_wr1_data = rf_data;
    w_drop_nxt = 1'b0;
    if (w_both) begin
      w_wr0_data = (w_first_idx == REQ_RF) ? rf_data : alu_out;
      w_wr1_data = (w_first_idx == REQ_RF) ? alu_out : rf_data;
      if (w_free >= FW'(2)) begin
        w_wr0_en = 1'b1;
        w_wr1_en = 1'b1;
      end else begin
        w_wr0_en   = (w_free != '0);
        w_drop_nxt = 1'b1;
      end
    end else if (alu_vld || rf_vld) begin
      w_wr0_data = alu_vld ? alu_out : rf_data;
      w_wr0_en   = (w_free != '0);
      w_drop_nxt = (w_free == '0);
    end
  end

  tx_sched_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr0_en   (w_wr0_en),
    .wr0_data (w_wr0_data),
    .wr1_en   (w_wr1_en),
    .wr1_data (w_wr1_data),
    .rd_en    (w_pop),
    .rd_data  (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .free_cnt (w_free)
  );

  assign w_cnt_inc = (r_cnt == c_WAIT_MAX) ? r_cnt : r_cnt + CW'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_tx_p_data_nxt = r_tx_p_data;
    w_tx_d_vld_nxt  = 1'b0;
    w_timeout_nxt   = 1'b0;
    w_pop           = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !tx_busy) begin
          w_tx_p_data_nxt = w_head;
          w_tx_d_vld_nxt  = 1'b1;
          w_pop           = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          w_state_nxt = WAIT_LO;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == c_WAIT_MAX) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = IDLE;
          end
        end
      end
      WAIT_LO: begin
        if (!tx_busy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_tx_p_data <= '0;
      r_tx_d_vld  <= 1'b0;
      r_timeout   <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tx_p_data <= w_tx_p_data_nxt;
      r_tx_d_vld  <= w_tx_d_vld_nxt;
      r_timeout   <= w_timeout_nxt;
      r_drop      <= w_drop_nxt;
    end
  end

  assign tx_p_data = r_tx_p_data;
  assign tx_d_vld  = r_tx_d_vld;
  assign timeout   = r_timeout;
  assign drop      = r_drop;
  assign fifo_full = w_full;
  assign idle      = (r_state == IDLE) && w_empty;

endmodule
`default_nettype wire

// File: tb/tb_tx_resp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_resp_scheduler
// Brief    : Directed self-checking bench for tx_resp_scheduler.
// Revision : 1.0
// ============================================================================
module tb_tx_resp_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] alu_out, rf_data, tx_p_data;
  logic       alu_vld, rf_vld, tx_busy;
  logic       tx_d_vld, fifo_full, drop, timeout, idle;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tx_resp_scheduler #(
    .DATA_WIDTH    (8),
    .DEPTH         (4),
    .BUSY_WAIT_MAX (255)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_out   (alu_out),
    .alu_vld   (alu_vld),
    .rf_data   (rf_data),
    .rf_vld    (rf_vld),
    .tx_busy   (tx_busy),
    .tx_p_data (tx_p_data),
    .tx_d_vld  (tx_d_vld),
    .fifo_full (fifo_full),
    .drop      (drop),
    .timeout   (timeout),
    .idle      (idle)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    alu_vld = 1'b0;
    rf_vld  = 1'b0;
    tx_busy = 1'b0;
    rst_n   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Enters from WAIT_HI; leaves the FSM back in IDLE with tx_busy low.
  task automatic busy_handshake(input int hi);
    tx_busy = 1'b1;
    repeat (hi) step();
    tx_busy = 1'b0;
    step();
  endtask

  task automatic expect_send(input logic [7:0] exp, input string name);
    int waited = 0;
    while (tx_d_vld !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    n_vec++;
    if (tx_d_vld !== 1'b1) begin
      n_err++;
      $display("FAIL %s: tx_d_vld got %b want 1 within 20 cycles", name, tx_d_vld);
    end else if (tx_p_data !== exp) begin
      n_err++;
      $display("FAIL %s: tx_p_data got %h want %h", name, tx_p_data, exp);
    end
    if (tx_d_vld === 1'b1) busy_handshake(2);
  endtask

  task automatic test_reset();
    alu_out = 8'h00; rf_data = 8'h00;
    alu_vld = 1'b0;  rf_vld  = 1'b0; tx_busy = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    n_vec++;
    if ({tx_p_data, tx_d_vld, fifo_full, drop, timeout, idle} !== {8'h00, 5'b00001}) begin
      n_err++;
      $display("FAIL reset_values: got %h/%b%b%b%b%b want 00/00001",
               tx_p_data, tx_d_vld, fifo_full, drop, timeout, idle);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    alu_out = 8'hA5; alu_vld = 1'b1;
    step();
    alu_vld = 1'b0;
    n_vec++;
    if ({tx_d_vld, idle} !== 2'b00) begin
      n_err++;
      $display("FAIL single_queued: vld/idle got %b%b want 00", tx_d_vld, idle);
    end
    step();
    n_vec++;
    if (tx_d_vld !== 1'b1) begin
      n_err++;
      $display("FAIL single_vld: got %b want 1", tx_d_vld);
    end
    n_vec++;
    if (tx_p_data !== 8'hA5) begin
      n_err++;
      $display("FAIL single_data: got %h want a5", tx_p_data);
    end
    tx_busy = 1'b1;
    step();
    n_vec++;
    if (tx_d_vld !== 1'b0) begin
      n_err++;
      $display("FAIL single_vld_one_cycle: got %b want 0", tx_d_vld);
    end
    repeat (4) step();
    n_vec++;
    if (idle !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy_idle: got %b want 0", idle);
    end
    tx_busy = 1'b0;
    step();
    n_vec++;
    if (idle !== 1'b1) begin
      n_err++;
      $display("FAIL single_back_idle: got %b want 1", idle);
    end
  endtask

  task automatic test_both();
    logic seen = 1'b0;
    alu_out = 8'h11; alu_vld = 1'b1;
    rf_data = 8'h22; rf_vld  = 1'b1;
    step();
    alu_vld = 1'b0; rf_vld = 1'b0;
    step();
    n_vec++;
    if ({tx_d_vld, tx_p_data} !== {1'b1, 8'h11}) begin
      n_err++;
      $display("FAIL both_first: vld/data got %b/%h want 1/11", tx_d_vld, tx_p_data);
    end
    repeat (3) begin
      step();
      if (tx_d_vld === 1'b1) seen = 1'b1;
    end
    tx_busy = 1'b1;
    repeat (2) begin
      step();
      if (tx_d_vld === 1'b1) seen = 1'b1;
    end
    tx_busy = 1'b0;
    step();
    if (tx_d_vld === 1'b1) seen = 1'b1;
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL both_paced: early second send got %b want 0", seen);
    end
    step();
    n_vec++;
    if ({tx_d_vld, tx_p_data} !== {1'b1, 8'h22}) begin
      n_err++;
      $display("FAIL both_second: vld/data got %b/%h want 1/22", tx_d_vld, tx_p_data);
    end
    busy_handshake(2);
  endtask

  task automatic test_fill_drop();
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_out = 8'h31 + 8'(i);
      alu_vld = 1'b1;
      step();
    end
    alu_vld = 1'b0;
    n_vec++;
    if ({fifo_full, drop} !== 2'b10) begin
      n_err++;
      $display("FAIL fill_full: full/drop got %b%b want 10", fifo_full, drop);
    end
    rf_data = 8'h35; rf_vld = 1'b1;
    step();
    rf_vld = 1'b0;
    n_vec++;
    if ({fifo_full, drop} !== 2'b11) begin
      n_err++;
      $display("FAIL fill_drop: full/drop got %b%b want 11", fifo_full, drop);
    end
    step();
    n_vec++;
    if (drop !== 1'b0) begin
      n_err++;
      $display("FAIL fill_drop_pulse: got %b want 0", drop);
    end
    tx_busy = 1'b0;
    expect_send(8'h31, "fill_out0");
    expect_send(8'h32, "fill_out1");
    expect_send(8'h33, "fill_out2");
    expect_send(8'h34, "fill_out3");
    n_vec++;
    if ({idle, fifo_full} !== 2'b10) begin
      n_err++;
      $display("FAIL fill_drained: idle/full got %b%b want 10", idle, fifo_full);
    end
  endtask

  task automatic test_priority(input logic [7:0] base, input logic expect_rf);
    tx_busy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      alu_out = base + 8'(i);
      alu_vld = 1'b1;
      step();
    end
    alu_out = base + 8'h04; alu_vld = 1'b1;
    rf_data = base + 8'h0F; rf_vld  = 1'b1;
    step();
    alu_vld = 1'b0; rf_vld = 1'b0;
    n_vec++;
    if ({fifo_full, drop} !== 2'b11) begin
      n_err++;
      $display("FAIL prio_drop %h: full/drop got %b%b want 11", base, fifo_full, drop);
    end
    tx_busy = 1'b0;
    expect_send(base + 8'h01, "prio_out0");
    expect_send(base + 8'h02, "prio_out1");
    expect_send(base + 8'h03, "prio_out2");
    expect_send(expect_rf ? base + 8'h0F : base + 8'h04, "prio_winner");
    n_vec++;
    if (idle !== 1'b1) begin
      n_err++;
      $display("FAIL prio_idle %h: got %b want 1", base, idle);
    end
  endtask

  task automatic test_timeout();
    alu_out = 8'h81; alu_vld = 1'b1;
    step();
    alu_out = 8'h82;
    step();
    alu_vld = 1'b0;
    n_vec++;
    if ({tx_d_vld, tx_p_data} !== {1'b1, 8'h81}) begin
      n_err++;
      $display("FAIL to_send: vld/data got %b/%h want 1/81", tx_d_vld, tx_p_data);
    end
    repeat (254) step();
    n_vec++;
    if (timeout !== 1'b0) begin
      n_err++;
      $display("FAIL to_early: got %b want 0 after 254 wait cycles", timeout);
    end
    step();
    n_vec++;
    if ({timeout, tx_d_vld} !== 2'b10) begin
      n_err++;
      $display("FAIL to_pulse: timeout/vld got %b%b want 10", timeout, tx_d_vld);
    end
    step();
    n_vec++;
    if ({timeout, tx_d_vld, tx_p_data} !== {2'b01, 8'h82}) begin
      n_err++;
      $display("FAIL to_next: timeout/vld/data got %b%b/%h want 01/82", timeout, tx_d_vld, tx_p_data);
    end
    busy_handshake(2);
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      alu_out = 8'h90 + 8'(i);
      alu_vld = 1'b1;
      step();
    end
    alu_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({tx_p_data, tx_d_vld, fifo_full, drop, timeout, idle} !== {8'h00, 5'b00001}) begin
      n_err++;
      $display("FAIL mid_reset: got %h/%b%b%b%b%b want 00/00001",
               tx_p_data, tx_d_vld, fifo_full, drop, timeout, idle);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      step();
      if (tx_d_vld !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if ({seen, idle} !== 2'b01) begin
      n_err++;
      $display("FAIL mid_after: stray_send/idle got %b%b want 01", seen, idle);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_fill_drop();
    apply_reset();
    test_priority(8'h40, 1'b0);
`ifdef TX_SCHED_RR_EN
    test_priority(8'h60, 1'b1);
`else
    test_priority(8'h60, 1'b0);
`endif
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
